// File: rtl/ego1_io_pkg.sv
// ego1_io_pkg: board-level constants shared by the EGO1 I/O conditioning blocks.
//   SYS_CLK_HZ         - system clock frequency (100 MHz)
//   SW_DEBOUNCE_MS     - switch debounce hold time in milliseconds
//   SW_DEBOUNCE_CYCLES - hold time expressed in system clocks
//   SW_NUM / LED_NUM   - number of DIP switches / LEDs on the board
//   db_state_e         - per-channel debounce FSM state
package ego1_io_pkg;

    localparam int unsigned SYS_CLK_HZ     = 32'd100_000_000;
    localparam int unsigned SW_DEBOUNCE_MS = 32'd10;
    localparam int unsigned SW_NUM         = 32'd8;
    localparam int unsigned LED_NUM        = 32'd16;

    // Convert a duration in milliseconds to a number of system clocks.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (SYS_CLK_HZ / 32'd1000) * ms;
    endfunction

    localparam int unsigned SW_DEBOUNCE_CYCLES = ms_to_cycles(SW_DEBOUNCE_MS);

    typedef enum logic [0:0] {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one switch channel - 2-flop synchroniser, hold counter,
// two-state debounce FSM and (optionally) registered edge pulses.
//   clk, rst_n - system clock, asynchronous active-low reset
//   sw_pin     - raw asynchronous switch level
//   sw_db      - debounced, registered level
//   sw_rise    - one-cycle pulse when sw_db goes 0->1 (SW_DEBOUNCE_EDGE_EN only)
//   sw_fall    - one-cycle pulse when sw_db goes 1->0 (SW_DEBOUNCE_EDGE_EN only)
// Optional feature macro: SW_DEBOUNCE_EDGE_EN
module sw_debounce_bit
    import ego1_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
)(
    input  logic clk,
    input  logic rst_n,
    input  logic sw_pin,
    output logic sw_db
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic sw_rise,
    output logic sw_fall
`endif
);

    localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(32'd1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(32'd0);

    logic          s1_q;
    logic          s2_q;
    db_state_e     state_q;
    db_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_q;
    logic          db_d;

    // Two-flop synchroniser bringing the raw pin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sw_pin;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM state, hold counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DB_IDLE;
            cnt_q   <= CNT_ZERO;
            db_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // Next-state logic: a new level must differ from the accepted one for
    // DEBOUNCE_CYCLES consecutive clocks; any return to the old level aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        case (state_q)
            DB_IDLE: begin
                if (s2_q != db_q) begin
                    state_d = DB_COUNT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            DB_COUNT: begin
                if (s2_q == db_q) begin
                    state_d = DB_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DB_IDLE;
                    cnt_d   = CNT_ZERO;
                    db_d    = s2_q;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign sw_db = db_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Edge pulses registered alongside db_q so they line up with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= db_d & ~db_q;
            fall_q <= ~db_d & db_q;
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
`endif

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: DIP-switch conditioning for the EGO1 board. WIDTH independent
// synchroniser/debounce channels produce a clean registered switch vector.
//   clk, rst_n - system clock, asynchronous active-low reset
//   sw_pin     - raw asynchronous switch levels [WIDTH]
//   sw_db      - debounced switch levels [WIDTH]
//   sw_rise    - per-bit 0->1 pulses [WIDTH] (SW_DEBOUNCE_EDGE_EN only)
//   sw_fall    - per-bit 1->0 pulses [WIDTH] (SW_DEBOUNCE_EDGE_EN only)
// Optional feature macro: SW_DEBOUNCE_EDGE_EN
module sw_debounce
    import ego1_io_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_NUM,
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_pin,
    output logic [WIDTH-1:0] sw_db
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_pin  (sw_pin[i]),
            .sw_db   (sw_db[i])
`ifdef SW_DEBOUNCE_EDGE_EN
            ,
            .sw_rise (sw_rise[i]),
            .sw_fall (sw_fall[i])
`endif
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: self-checking bench for sw_debounce with WIDTH=8 and
// DEBOUNCE_CYCLES=4. Edge-pulse checks are included when SW_DEBOUNCE_EDGE_EN
// is defined.
module tb_sw_debounce;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_pin;
    logic [7:0] sw_db;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_pin  (sw_pin),
        .sw_db   (sw_db)
`ifdef SW_DEBOUNCE_EDGE_EN
        ,
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
`endif
    );

`ifndef SW_DEBOUNCE_EDGE_EN
    assign sw_rise = 8'h00;
    assign sw_fall = 8'h00;
`endif

    // Reference model: a level is accepted once the synchronised samples seen
    // by the filter (pin value from two edges earlier) have differed from the
    // accepted level for the last D edges in a row.
    logic [7:0] pin_hist[$];
    logic [7:0] filt_hist[$];
    logic [7:0] m_db, m_rise, m_fall;

    task automatic model_reset();
        pin_hist.delete();
        filt_hist.delete();
        m_db   = 8'h00;
        m_rise = 8'h00;
        m_fall = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] pin);
        logic [7:0] filt;
        logic [7:0] old;
        bit         all_diff;
        pin_hist.push_back(pin);
        if (pin_hist.size() > 3) void'(pin_hist.pop_front());
        filt = (pin_hist.size() == 3) ? pin_hist[0] : 8'h00;
        filt_hist.push_back(filt);
        if (filt_hist.size() > D) void'(filt_hist.pop_front());
        old = m_db;
        for (int b = 0; b < 8; b++) begin
            if (filt_hist.size() == D) begin
                all_diff = 1'b1;
                foreach (filt_hist[j]) if (filt_hist[j][b] == old[b]) all_diff = 1'b0;
                if (all_diff) m_db[b] = ~old[b];
            end
        end
        m_rise = m_db & ~old;
        m_fall = ~m_db & old;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one pin vector across one clock edge and compare against the model.
    task automatic tick(input logic [7:0] pin);
        sw_pin = pin;
        @(posedge clk);
        model_step(pin);
        #1;
        check("db_model", sw_db, m_db);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("rise_model", sw_rise, m_rise);
        check("fall_model", sw_fall, m_fall);
`endif
    endtask

    typedef struct {
        logic [7:0] pin;
        logic [7:0] db;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;

    vec_t tbl[$];

    // Hold pin for n edges; the new level appears on the 6th edge (index 5).
    task automatic add_hold(input logic [7:0] pin, input logic [7:0] from_db, input int n);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.pin  = pin;
            v.db   = (k >= 5) ? pin : from_db;
            v.rise = (k == 5) ? (pin & ~from_db) : 8'h00;
            v.fall = (k == 5) ? (~pin & from_db) : 8'h00;
            tbl.push_back(v);
        end
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] seen;

        rst_n  = 1'b0;
        sw_pin = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_db", sw_db, 8'h00);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("reset_rise", sw_rise, 8'h00);
        check("reset_fall", sw_fall, 8'h00);
`endif
        rst_n = 1'b1;

        // Clean step on bit 0, its release, then all-parallel A5 up and down.
        add_hold(8'h01, 8'h00, 8);
        add_hold(8'h00, 8'h01, 8);
        add_hold(8'hA5, 8'h00, 8);
        add_hold(8'h00, 8'hA5, 8);
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].pin);
            check("tbl_db", sw_db, tbl[i].db);
`ifdef SW_DEBOUNCE_EDGE_EN
            check("tbl_rise", sw_rise, tbl[i].rise);
            check("tbl_fall", sw_fall, tbl[i].fall);
`endif
        end

        // Bounce on bit 1: 1,0,1,0 then hold 0.
        seen = 8'h00;
        tick(8'h02); seen |= sw_db | sw_rise | sw_fall;
        tick(8'h00); seen |= sw_db | sw_rise | sw_fall;
        tick(8'h02); seen |= sw_db | sw_rise | sw_fall;
        for (int k = 0; k < 9; k++) begin
            tick(8'h00);
            seen |= sw_db | sw_rise | sw_fall;
        end
        check("bounce_quiet", seen, 8'h00);

        // Bit 2 high for 3 edges: rejected.
        seen = 8'h00;
        for (int k = 0; k < 3; k++) begin tick(8'h04); seen |= sw_db; end
        for (int k = 0; k < 8; k++) begin tick(8'h00); seen |= sw_db; end
        check("glitch3_rejected", seen, 8'h00);

        // Bit 2 high for 4 edges: accepted.
        seen = 8'h00;
        for (int k = 0; k < 4; k++) begin tick(8'h04); seen |= sw_db; end
        for (int k = 0; k < 8; k++) begin tick(8'h00); seen |= sw_db; end
        check("pulse4_accepted", seen, 8'h04);
        check("pulse4_released", sw_db, 8'h00);

        // Reset two cycles into a count with sw_db = FF.
        for (int k = 0; k < 8; k++) tick(8'hFF);
        check("all_high", sw_db, 8'hFF);
        for (int k = 0; k < 4; k++) tick(8'h00);
        check("mid_count_hold", sw_db, 8'hFF);
        sw_pin = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_db", sw_db, 8'h00);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("async_rst_rise", sw_rise, 8'h00);
        check("async_rst_fall", sw_fall, 8'h00);
`endif
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 7; k++) begin
            tick(8'hFF);
            check("post_rst_db", sw_db, (k >= 5) ? 8'hFF : 8'h00);
`ifdef SW_DEBOUNCE_EDGE_EN
            check("post_rst_rise", sw_rise, (k == 5) ? 8'hFF : 8'h00);
`endif
        end

        // Randomised per-bit toggling against the model.
        cur = 8'hFF;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            tick(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

- Input conditioning stage for the EGO1 board's DIP switches.
- Synchronises each raw `sw_pin` line into the system clock domain and filters contact bounce.
- Presents a clean, registered switch vector to the downstream combinational logic, which drives `led_pin`.
- One independent synchroniser/debounce channel per switch bit; optional single-cycle edge pulses.

## Interface
- `WIDTH`, default 8: number of switch channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: clocks an input must hold a new level before it is accepted (10 ms at 100 MHz). Legal range ≥ 2.
- `clk` input 1: system clock, 100 MHz on EGO1.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `sw_pin` input WIDTH: raw, asynchronous switch levels.
- `sw_db` output WIDTH: debounced switch levels; feeds the downstream logic stage.
- `sw_rise` output WIDTH: one-cycle pulse when `sw_db[i]` goes 0→1. Present only with `SW_DEBOUNCE_EDGE_EN`.
- `sw_fall` output WIDTH: one-cycle pulse when `sw_db[i]` goes 1→0. Present only with `SW_DEBOUNCE_EDGE_EN`.

## Operation
- Each channel `i` is fully independent. The per-channel path is:
  - 2-flop synchroniser `s1`, `s2` on `sw_pin[i]`;
  - counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`;
  - stable register `sw_db[i]`.
- Per-channel FSM:
  - IDLE: `s2 == sw_db[i]`, `cnt == 0`. If `s2 != sw_db[i]`, go to COUNT with `cnt <= 1`.
  - COUNT, `s2 != sw_db[i]`, `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - COUNT, `s2 != sw_db[i]`, `cnt == DEBOUNCE_CYCLES-1`: `sw_db[i] <= s2`, `cnt <= 0`, go to IDLE.
  - COUNT, `s2 == sw_db[i]` (bounce back): `cnt <= 0`, go to IDLE. No output change.
- Glitches shorter than `DEBOUNCE_CYCLES` clocks after synchronisation never reach `sw_db`.
- Simultaneous changes on several channels are handled in parallel, with no priority or interaction.
- The counter never wraps; it is cleared on acceptance or abort.
- Asynchronous reset, including mid-count:
  - `s1`, `s2`, `cnt` and `sw_db` clear to 0.
  - `sw_rise` and `sw_fall` clear to 0.
  - Any in-flight count is discarded.
- After reset release, a switch already high is accepted as a normal 0→1 change, so `sw_rise` fires once.

## Timing
- Latency: `sw_pin[i]` stable from clock edge N appears on `sw_db[i]` after edge N+2+DEBOUNCE_CYCLES.
  - 2 synchroniser edges, then DEBOUNCE_CYCLES counting edges.
- `sw_db` is purely registered, with no combinational path from `sw_pin`.
- `sw_rise` / `sw_fall` are registered. They assert in the same cycle `sw_db[i]` takes its new value, for exactly one cycle.
- Reset values of all outputs: 0.
- Reset is asserted asynchronously and deasserted synchronously to `clk` by the board-level reset logic.

## Configuration
- `SW_DEBOUNCE_EDGE_EN` defined:
  - `sw_rise` and `sw_fall` ports and their registers are present.
  - Each pulse equals `sw_db_new & ~sw_db_old`, or the inverse for `sw_fall`, registered.
- `SW_DEBOUNCE_EDGE_EN` undefined:
  - Those ports and registers are absent.
  - `sw_db` behaviour and timing are identical in both builds.

## Structure
- Shared package `ego1_io_pkg`:
  - `SYS_CLK_HZ = 100_000_000`;
  - `SW_DEBOUNCE_MS = 10`;
  - derived constant `SW_DEBOUNCE_CYCLES`;
  - `SW_NUM = 8`, `LED_NUM = 16`.
- Top-level default of `DEBOUNCE_CYCLES` comes from `ego1_io_pkg::SW_DEBOUNCE_CYCLES`.
- Sub-module `sw_debounce_bit`: one channel (synchroniser, counter, FSM, optional edge register). It is instantiated WIDTH times in a generate loop.

## Test plan
Directed scenarios, all with `DEBOUNCE_CYCLES=4` and `SW_DEBOUNCE_EDGE_EN` defined:
- **Clean step:** `sw_pin[0]` 0→1 held at edge N → `sw_db[0]=1` after edge N+6; `sw_rise[0]` high for that one cycle only; other bits 0.
- **Bounce rejection:** `sw_pin[1]` toggles 1,0,1,0 on consecutive cycles, then holds 0 → `sw_db[1]` stays 0; no pulses.
- **Near-threshold glitch:** `sw_pin[2]` high for exactly 3 synchronised cycles, then low → `sw_db[2]` stays 0. Held for 4 cycles → accepted.
- **Parallel channels:** `sw_pin=8'hA5` in one cycle → `sw_db=8'hA5` six edges later. `sw_rise=8'hA5` for one cycle, then `sw_pin=8'h00` → `sw_fall=8'hA5`.
- **Reset mid-count:** assert `rst_n=0` two cycles into a count with `sw_db=8'hFF`:
  - `sw_db`, `sw_rise` and `sw_fall` go to 0 immediately (asynchronously).
  - After release with the pins still high, `sw_db=8'hFF` six edges later, with one `sw_rise` pulse.
- **Macro off:** build without `SW_DEBOUNCE_EDGE_EN` → the clean-step and parallel scenarios give identical `sw_db` traces.
